// File: rtl/sar_ctrl.sv
// sar_ctrl - successive-approximation controller driving the bottom plates of
// a capacitive DAC array. Samples the input, resolves one bit per TRIAL/DECIDE
// pair from MSB to LSB using the comparator, then presents the code on dout.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          conversion request (honoured in IDLE and DONE only)
//   comp_out       comparator decision, 1 = keep the trial bit
//   sample_en      top-plate sampling switch enable
//   comp_en        comparator latch strobe, one cycle per bit
//   cap_botplate_m main-cap bottom-plate drive
//   cap_botplate_d diff-cap bottom-plate drive (~m whenever not idle)
//   dout           last conversion result
//   dout_valid     one-cycle pulse when dout updates
//   busy           high in SAMPLE, TRIAL and DECIDE
//
// state  | meaning
// IDLE   | plates discharged, waiting for start
// SAMPLE | top plate tracking input for SAMPLE_CYCLES cycles
// TRIAL  | trial bit applied to the array, comparator strobed
// DECIDE | comparator result latched into code bit i
// DONE   | result published, optional back-to-back restart

module sar_ctrl #(
  parameter int NBITS         = 16,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             comp_out,
  output logic             sample_en,
  output logic             comp_en,
  output logic [NBITS-1:0] cap_botplate_m,
  output logic [NBITS-1:0] cap_botplate_d,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [NBITS-1:0] LSB_ONE = NBITS'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    TRIAL  = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [NBITS-1:0] d_q, d_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             sample_en_q, sample_en_d;
  logic             comp_en_q, comp_en_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    code_d       = code_q;
    dout_d       = dout_q;
    m_d          = '0;
    d_d          = '0;
    sample_en_d  = 1'b0;
    comp_en_d    = 1'b0;
    dout_valid_d = 1'b0;
    busy_d       = 1'b0;

    // Next-state and datapath update.
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = CW'(SAMPLE_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SAMPLE: begin
        // Down-counter: terminal count 0 ends the sampling window.
        if (cnt_q == '0) begin
          state_d = TRIAL;
          bit_d   = IW'(NBITS - 1);
          code_d  = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TRIAL: begin
        state_d = DECIDE;
      end
      DECIDE: begin
        code_d[bit_q] = comp_out;
        if (bit_q == '0) begin
          state_d = DONE;
          dout_d  = code_d;
        end else begin
          state_d = TRIAL;
          bit_d   = bit_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register
    // alongside it; nothing combinational reaches the ports.
    unique case (state_d)
      IDLE: ;
      SAMPLE: begin
        sample_en_d = 1'b1;
        busy_d      = 1'b1;
        d_d         = '1;
      end
      TRIAL: begin
        m_d       = code_d | (LSB_ONE << bit_d);
        d_d       = ~m_d;
        comp_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      DECIDE: begin
        m_d    = m_q;
        d_d    = d_q;
        busy_d = 1'b1;
      end
      DONE: begin
        m_d          = code_d;
        d_d          = ~code_d;
        dout_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      code_q       <= '0;
      m_q          <= '0;
      d_q          <= '0;
      dout_q       <= '0;
      sample_en_q  <= 1'b0;
      comp_en_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      code_q       <= code_d;
      m_q          <= m_d;
      d_q          <= d_d;
      dout_q       <= dout_d;
      sample_en_q  <= sample_en_d;
      comp_en_q    <= comp_en_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign sample_en      = sample_en_q;
  assign comp_en        = comp_en_q;
  assign cap_botplate_m = m_q;
  assign cap_botplate_d = d_q;
  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Testbench for sar_ctrl: default 16-bit instance plus an 8-bit,
// single-sample-cycle instance. The comparator is modelled as an ideal
// comparison of the main-plate code against a held input value, so a
// correct conversion must return exactly that value.

module tb_sar_ctrl;

  localparam int SC = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        comp_out;
  logic        sample_en, comp_en, dout_valid, busy;
  logic [15:0] m, d, dout;

  logic        start8;
  logic        comp8;
  logic        sample_en8, comp_en8, dout_valid8, busy8;
  logic [7:0]  m8, d8, dout8;

  int n_checks = 0;
  int n_pass   = 0;

  // observations from run_conv
  int          n_comp, n_samp, n_valid, first_valid, second_valid, inv_err, samp_first;
  logic [15:0] dout_v1, dout_v2, trial_m, trial_d, mid_dout;
  logic        busy_at_valid;

  sar_ctrl #(.NBITS(16), .SAMPLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .comp_out(comp_out),
    .sample_en(sample_en), .comp_en(comp_en),
    .cap_botplate_m(m), .cap_botplate_d(d),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  sar_ctrl #(.NBITS(8), .SAMPLE_CYCLES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .comp_out(comp8),
    .sample_en(sample_en8), .comp_en(comp_en8),
    .cap_botplate_m(m8), .cap_botplate_d(d8),
    .dout(dout8), .dout_valid(dout_valid8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One conversion (or two when hold=1), start raised at the current negedge.
  // Cycle c is the c-th clock period after the start-sampling edge.
  task automatic run_conv(input logic [15:0] v1, input logic [15:0] v2,
                          input bit hold, input int extra_c, input int ncyc);
    logic [15:0] vin;
    vin = v1;
    n_comp = 0; n_samp = 0; n_valid = 0; first_valid = 0; second_valid = 0;
    inv_err = 0; samp_first = 0; dout_v1 = '0; dout_v2 = '0;
    trial_m = '0; trial_d = '0; mid_dout = '0; busy_at_valid = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (extra_c > 0 && c == extra_c) start = 1'b1;
      if (extra_c > 0 && c == extra_c + 1) start = 1'b0;
      if (sample_en) begin
        n_samp++;
        if (samp_first == 0) samp_first = c;
      end
      if (comp_en) n_comp++;
      if (c == SC + 1) begin
        trial_m = m;
        trial_d = d;
      end
      if (c == 50) mid_dout = dout;
      if (dout_valid) begin
        n_valid++;
        if (n_valid == 1) begin
          first_valid = c; dout_v1 = dout; busy_at_valid = busy; vin = v2;
        end else if (n_valid == 2) begin
          second_valid = c; dout_v2 = dout;
        end
      end
      if (busy || dout_valid) begin
        if (d !== ~m) inv_err++;
      end else if (m !== 16'h0 || d !== 16'h0) begin
        inv_err++;
      end
      comp_out = (m <= vin);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [51:0] o;
    logic [27:0] o8;
    rst_n = 1'b0; start = 1'b0; comp_out = 1'b0; start8 = 1'b0; comp8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = {m, d, dout, sample_en, comp_en, dout_valid, busy};
      n_checks++;
      if (o !== '0) $display("FAIL reset_hold cycle %0d: got %h want 0", i, o);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      comp_out = $urandom_range(0, 1);
      o  = {m, d, dout, sample_en, comp_en, dout_valid, busy};
      o8 = {m8, d8, dout8, sample_en8, comp_en8, dout_valid8, busy8};
      n_checks++;
      if (o !== '0 || o8 !== '0) $display("FAIL idle cycle %0d: got %h / %h want 0", i, o, o8);
      else n_pass++;
    end
  endtask

  task automatic test_ideal();
    run_conv(16'hA5C3, 16'hA5C3, 1'b0, 0, 40);
    n_checks++; if (n_samp !== SC || samp_first !== 1) $display("FAIL ideal_sample: got %0d cycles from %0d want 2 from 1", n_samp, samp_first); else n_pass++;
    n_checks++; if (n_comp !== 16) $display("FAIL ideal_comp_en: got %0d want 16", n_comp); else n_pass++;
    n_checks++; if (first_valid !== 35 || n_valid !== 1) $display("FAIL ideal_valid: got cycle %0d count %0d want 35 count 1", first_valid, n_valid); else n_pass++;
    n_checks++; if (dout_v1 !== 16'hA5C3) $display("FAIL ideal_dout: got %h want a5c3", dout_v1); else n_pass++;
    n_checks++; if (inv_err !== 0) $display("FAIL ideal_plate_invariant: got %0d violations want 0", inv_err); else n_pass++;
    n_checks++; if (busy_at_valid !== 1'b0) $display("FAIL ideal_busy_done: got %b want 0", busy_at_valid); else n_pass++;
    n_checks++; if (trial_m !== 16'h8000 || trial_d !== 16'h7FFF) $display("FAIL msb_trial: got m=%h d=%h want 8000/7fff", trial_m, trial_d); else n_pass++;
    @(negedge clk);
    n_checks++; if (dout !== 16'hA5C3 || busy !== 1'b0) $display("FAIL dout_hold: got %h busy %b want a5c3 0", dout, busy); else n_pass++;
  endtask

  task automatic test_extremes();
    logic [15:0] vals [4];
    vals[0] = 16'h0000; vals[1] = 16'hFFFF;
    vals[2] = 16'($urandom_range(0, 65535)); vals[3] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < 4; k++) begin
      run_conv(vals[k], vals[k], 1'b0, 0, 38);
      n_checks++; if (dout_v1 !== vals[k] || first_valid !== 35) $display("FAIL conv_%h: got dout %h at cycle %0d want %h at 35", vals[k], dout_v1, first_valid, vals[k]); else n_pass++;
      n_checks++; if (inv_err !== 0 || n_comp !== 16) $display("FAIL conv_%h_plates: got %0d violations %0d strobes want 0/16", vals[k], inv_err, n_comp); else n_pass++;
      n_checks++; if (trial_m !== 16'h8000 || trial_d !== 16'h7FFF) $display("FAIL conv_%h_msb_trial: got %h/%h want 8000/7fff", vals[k], trial_m, trial_d); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    run_conv(16'h1234, 16'h8001, 1'b1, 0, 70);
    n_checks++; if (first_valid !== 35 || dout_v1 !== 16'h1234) $display("FAIL b2b_first: got %h at %0d want 1234 at 35", dout_v1, first_valid); else n_pass++;
    n_checks++; if (second_valid !== 70 || dout_v2 !== 16'h8001) $display("FAIL b2b_second: got %h at %0d want 8001 at 70", dout_v2, second_valid); else n_pass++;
    n_checks++; if (mid_dout !== 16'h1234) $display("FAIL b2b_dout_stable: got %h want 1234", mid_dout); else n_pass++;
    n_checks++; if (n_comp !== 32 || inv_err !== 0) $display("FAIL b2b_strobes: got %0d strobes %0d violations want 32/0", n_comp, inv_err); else n_pass++;
    do_reset();
  endtask

  task automatic test_ignored_start();
    run_conv(16'h3C5A, 16'h3C5A, 1'b0, 5, 70);
    n_checks++; if (n_valid !== 1 || n_samp !== SC) $display("FAIL ignored_start: got %0d valids %0d sample cycles want 1/2", n_valid, n_samp); else n_pass++;
    n_checks++; if (dout_v1 !== 16'h3C5A || n_comp !== 16) $display("FAIL ignored_start_dout: got %h %0d strobes want 3c5a 16", dout_v1, n_comp); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [51:0]  o;
    logic [15:0]  v;
    start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      comp_out = (m <= 16'h6BD2);
    end
    n_checks++; if (busy !== 1'b1 || dout !== 16'h3C5A) $display("FAIL areset_pre: got busy %b dout %h want 1 3c5a", busy, dout); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    o = {m, d, dout, sample_en, comp_en, dout_valid, busy};
    n_checks++; if (o !== '0) $display("FAIL areset_immediate: got %h want 0", o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = 16'($urandom_range(0, 65535));
    run_conv(v, v, 1'b0, 0, 38);
    n_checks++; if (dout_v1 !== v || first_valid !== 35 || inv_err !== 0) $display("FAIL areset_recover: got %h at %0d want %h at 35", dout_v1, first_valid, v); else n_pass++;
  endtask

  task automatic test_param();
    logic [7:0] vals [2];
    int nc, nv, fv;
    logic [7:0] dv;
    vals[0] = 8'h5A; vals[1] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 2; k++) begin
      nc = 0; nv = 0; fv = 0; dv = '0;
      start8 = 1'b1;
      for (int c = 1; c <= 22; c++) begin
        @(negedge clk);
        if (c == 1) start8 = 1'b0;
        if (comp_en8) nc++;
        if (dout_valid8) begin
          nv++;
          if (fv == 0) begin fv = c; dv = dout8; end
        end
        comp8 = (m8 <= vals[k]);
      end
      n_checks++; if (dv !== vals[k] || fv !== 18 || nv !== 1) $display("FAIL nbits8_%h: got %h at %0d (%0d valids) want %h at 18", vals[k], dv, fv, nv, vals[k]); else n_pass++;
      n_checks++; if (nc !== 8) $display("FAIL nbits8_%h_strobes: got %0d want 8", vals[k], nc); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_extremes();
    test_back_to_back();
    test_ignored_start();
    test_async_reset();
    test_param();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
